// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART receiver: FSM states,
// oversampling ratio and the sample indices used for bit decisions.
package dbg_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int OVERSAMPLE = 16;

   localparam logic [3:0] SMP_A    = 4'd7;
   localparam logic [3:0] SMP_B    = 4'd8;
   localparam logic [3:0] SMP_C    = 4'd9;
   localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/dbg_uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks, held at
// zero while restart_i is high so the first tick lands a full period later.
module dbg_uart_tick_gen #(
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = !restart_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dbg_uart_rx.sv
// 8N1-style debug UART receiver with 16x oversampling, 3-sample majority
// voting per bit and a one-entry valid/ready holding register.
module dbg_uart_rx
   import dbg_uart_pkg::*;
#(
   parameter int TICK_DIV  = 10,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int BCW = $clog2(DATA_BITS + 1);

   logic                 rx_meta_q, rx_sync_q;
   uart_state_e          state_q, state_d;
   logic [3:0]           smp_q, smp_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           hist_q, hist_d;
   logic                 stop_done_q, stop_done_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 tick;
   logic                 deliver;
   logic                 vote;

   dbg_uart_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk       (clk),
      .reset     (reset),
      .restart_i (state_q == ST_IDLE),
      .tick_o    (tick)
   );

   assign vote = maj3(hist_q[0], hist_q[1], rx_sync_q);

   always_comb begin
      state_d     = state_q;
      smp_d       = smp_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      hist_d      = hist_q;
      stop_done_d = stop_done_q;
      deliver     = 1'b0;
      ferr_d      = 1'b0;

      // The 4-bit sample counter wraps 15 -> 0 on its own at each bit boundary.
      if (tick) begin
         smp_d = smp_q + 4'd1;
         if (smp_q == SMP_A) hist_d[0] = rx_sync_q;
         if (smp_q == SMP_B) hist_d[1] = rx_sync_q;
      end

      case (state_q)
         ST_IDLE: begin
            smp_d       = '0;
            bit_cnt_d   = '0;
            stop_done_d = 1'b0;
            if (!rx_sync_q) state_d = ST_START;
         end
         ST_START: begin
            if (tick) begin
               if ((smp_q == SMP_A) && rx_sync_q) begin
                  state_d = ST_IDLE;
               end else if (smp_q == SMP_LAST) begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (smp_q == SMP_C) begin
                  shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
               if ((smp_q == SMP_LAST) && (bit_cnt_q == BCW'(DATA_BITS))) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            // After the decision, wait for an idle line so a held break cannot start a frame.
            if (stop_done_q) begin
               if (rx_sync_q) state_d = ST_IDLE;
            end else if (tick && (smp_q == SMP_C)) begin
               stop_done_d = 1'b1;
               if (vote) deliver = 1'b1;
               else      ferr_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (valid_q && ready_i) valid_d = 1'b0;
      if (deliver) begin
         if (!valid_q || ready_i) begin
            hold_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         state_q     <= ST_IDLE;
         smp_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hist_q      <= '0;
         stop_done_q <= 1'b0;
         hold_q      <= '0;
         valid_q     <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         rx_meta_q   <= rx_i;
         rx_sync_q   <= rx_meta_q;
         state_q     <= state_d;
         smp_q       <= smp_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hist_q      <= hist_d;
         stop_done_q <= stop_done_d;
         hold_q      <= hold_d;
         valid_q     <= valid_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

   assign data_o      = hold_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbg_uart_rx.sv
// Bench for dbg_uart_rx: vector table of whole frames, hand-written corner
// sequences, and random frames checked against a queue-based reference model.
module tb_dbg_uart_rx;

   localparam int TICK_DIV = 10;
   localparam int BIT      = 160;
   localparam int LAT_MIN  = 1512;
   localparam int LAT_MAX  = 1552;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   dbg_uart_rx #(
      .TICK_DIV  (TICK_DIV),
      .DATA_BITS (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Monitor, sampled on the falling edge.
   int         cyc = 0;
   int         n_valid_cyc = 0;
   int         n_ferr = 0;
   int         n_ovr = 0;
   logic [7:0] got_q[$];
   int         got_cyc_q[$];

   always @(negedge clk) begin
      cyc++;
      if (valid_o) n_valid_cyc++;
      if (valid_o && ready_i) begin
         got_q.push_back(data_o);
         got_cyc_q.push_back(cyc);
      end
      if (frame_err_o) n_ferr++;
      if (overrun_o) n_ovr++;
   end

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int edge_cyc;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok);
      edge_cyc = cyc;
      rx_i = 1'b0;
      step(BIT);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         step(BIT);
      end
      rx_i = stop_ok;
      step(BIT);
      rx_i = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      int         exp_beats;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int b0, f0, o0, v0, lat, k;
      bit mv, r, ok;
      logic [7:0] md, d;
      logic [7:0] exp_q[$];

      vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
      vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
      vecs[2] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
      vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vecs[5] = '{8'h5A, 1'b1, 1, 8'h5A, 0};

      reset   = 1'b0;
      rx_i    = 1'b1;
      ready_i = 1'b1;
      step(3);
      check("rst data_o", data_o, 0);
      check("rst valid_o", valid_o, 0);
      check("rst frame_err_o", frame_err_o, 0);
      check("rst overrun_o", overrun_o, 0);
      check("rst busy_o", busy_o, 0);
      reset = 1'b1;
      step(20);

      // Table of single frames with ready_i held high.
      for (int i = 0; i < 6; i++) begin
         b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr; v0 = n_valid_cyc;
         send_frame(vecs[i].data, vecs[i].stop_ok);
         step(20);
         check($sformatf("vec%0d beats", i), got_q.size() - b0, vecs[i].exp_beats);
         check($sformatf("vec%0d valid cycles", i), n_valid_cyc - v0, vecs[i].exp_beats);
         check($sformatf("vec%0d frame_err pulses", i), n_ferr - f0, vecs[i].exp_ferr);
         check($sformatf("vec%0d overrun pulses", i), n_ovr - o0, 0);
         if (got_q.size() > b0) begin
            check($sformatf("vec%0d data", i), got_q[b0], vecs[i].exp_data);
            lat = got_cyc_q[b0] - edge_cyc;
            n_cmp++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
               n_err++;
               $display("FAIL vec%0d latency: got %0d cycles expected %0d..%0d", i, lat, LAT_MIN, LAT_MAX);
            end
         end
      end

      // Start-bit glitch.
      b0 = got_q.size();
      rx_i = 1'b0;
      step(20);
      check("glitch busy during low", busy_o, 1);
      step(20);
      rx_i = 1'b1;
      k = 0;
      while (busy_o && k < 80) begin
         step(1);
         k++;
      end
      check("glitch busy cleared within 80", busy_o, 0);
      step(BIT * 2);
      check("glitch no beats", got_q.size() - b0, 0);

      // Back-to-back frames.
      b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      step(20);
      check("b2b beats", got_q.size() - b0, 2);
      if (got_q.size() - b0 == 2) begin
         check("b2b data0", got_q[b0], 8'h00);
         check("b2b data1", got_q[b0 + 1], 8'hFF);
      end
      check("b2b errors", (n_ferr - f0) + (n_ovr - o0), 0);

      // Overrun with consumer stalled.
      ready_i = 1'b0;
      o0 = n_ovr; b0 = got_q.size();
      send_frame(8'h11, 1'b1);
      step(5);
      check("ovr first valid", valid_o, 1);
      check("ovr first data", data_o, 8'h11);
      send_frame(8'h22, 1'b1);
      step(5);
      check("ovr pulses", n_ovr - o0, 1);
      check("ovr held data", data_o, 8'h11);
      check("ovr valid held", valid_o, 1);
      ready_i = 1'b1;
      step(1);
      step(1);
      check("ovr valid drops", valid_o, 0);
      check("ovr accepted beats", got_q.size() - b0, 1);
      if (got_q.size() > b0) check("ovr accepted data", got_q[b0], 8'h11);

      // Reset during data bit 4 with a byte already held.
      ready_i = 1'b0;
      send_frame(8'h77, 1'b1);
      step(5);
      check("pre-reset valid", valid_o, 1);
      rx_i = 1'b0;
      step(BIT);
      d = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         rx_i = d[i];
         step(BIT);
      end
      rx_i = d[4];
      step(BIT / 2);
      reset = 1'b0;
      step(1);
      check("midrst data_o", data_o, 0);
      check("midrst valid_o", valid_o, 0);
      check("midrst busy_o", busy_o, 0);
      check("midrst frame_err_o", frame_err_o, 0);
      check("midrst overrun_o", overrun_o, 0);
      step(4);
      rx_i = 1'b1;
      ready_i = 1'b1;
      reset = 1'b1;
      b0 = got_q.size(); f0 = n_ferr;
      step(BIT * 6);
      check("post-rst stray beats", got_q.size() - b0, 0);
      send_frame(8'h5A, 1'b1);
      step(20);
      check("post-rst beats", got_q.size() - b0, 1);
      if (got_q.size() > b0) check("post-rst data", got_q[b0], 8'h5A);
      check("post-rst frame_err", n_ferr - f0, 0);

      // Random frames against a queue-based model of the holding register.
      b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
      mv = 1'b0; md = '0;
      begin
         int exp_ferr, exp_ovr;
         exp_ferr = 0; exp_ovr = 0;
         for (int n = 0; n < 12; n++) begin
            r  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            ready_i = r;
            if (r && mv) begin
               exp_q.push_back(md);
               mv = 1'b0;
            end
            step($urandom_range(5, 40));
            send_frame(d, ok);
            if (!ok) exp_ferr++;
            else if (mv) exp_ovr++;
            else if (r) exp_q.push_back(d);
            else begin
               mv = 1'b1;
               md = d;
            end
         end
         ready_i = 1'b1;
         if (mv) exp_q.push_back(md);
         step(10);
         check("rand frame_err pulses", n_ferr - f0, exp_ferr);
         check("rand overrun pulses", n_ovr - o0, exp_ovr);
      end
      check("rand beat count", got_q.size() - b0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (b0 + i < got_q.size())
            check($sformatf("rand beat%0d data", i), got_q[b0 + i], exp_q[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dbg_uart_rx.md
DBG_UART_RX -- requirements
Module: dbg_uart_rx

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10: sysclk cycles per 1/16-bit oversample tick (18 MHz / (115200*16), rounded).
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic in this domain.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rx_i, input, 1: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port data_o, output, DATA_BITS: received byte, valid while valid_o=1.
REQ-007 SHALL have port valid_o, output, 1: byte available in holding register.
REQ-008 SHALL have port ready_i, input, 1: consumer accepts byte when valid_o&ready_i.
REQ-009 SHALL have port frame_err_o, output, 1: one-cycle pulse on stop-bit error.
REQ-010 SHALL have port overrun_o, output, 1: one-cycle pulse when a completed byte is dropped.
REQ-011 SHALL have port busy_o, output, 1: high in any state other than IDLE.

Function
REQ-012 SHALL pass rx_i through a 2-FF synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-013 SHALL generate a tick every TICK_DIV cycles; the tick counter restarts at 0 on leaving IDLE.
REQ-014 SHALL count ticks per bit with a 4-bit sample counter (0..15) that wraps at 15, marking a bit boundary.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on synchronized rx low; tick and sample counters cleared.
REQ-017 START: at sample 7, rx high -> IDLE (glitch rejected, no output); rx low -> continue; at sample 15 -> DATA.
REQ-018 DATA: each bit value SHALL be the majority of samples 7, 8, 9; bits shift in LSB first; after DATA_BITS bits -> STOP.
REQ-019 STOP: majority of samples 7, 8, 9 decided at sample 9; 1 -> deliver byte; 0 -> frame_err_o pulse, byte discarded.
REQ-020 STOP -> IDLE SHALL occur on the first cycle after the sample-9 decision in which synchronized rx is high (break held low does not retrigger frames).
REQ-021 A delivered byte SHALL load the holding register, with valid_o high the cycle after the decision.
REQ-022 valid_o SHALL clear the cycle after valid_o&ready_i when no new byte is delivered in the same cycle.
REQ-023 If delivery coincides with valid_o&ready_i, the new byte SHALL load and valid_o SHALL stay high.
REQ-024 If delivery occurs with valid_o=1 and ready_i=0, the old byte SHALL be kept, the new one dropped, and overrun_o pulsed.
REQ-025 data_o SHALL remain stable while valid_o=1 and not accepted.

Reset
REQ-026 On reset low: state IDLE, counters 0, synchronizer FFs 1, shift register 0, data_o 0, valid_o 0, frame_err_o 0, overrun_o 0, busy_o 0.
REQ-027 Reset mid-frame SHALL abort the frame with no output; the next full frame after release SHALL be received correctly.

Structure
REQ-028 Package dbg_uart_pkg SHALL hold the state enum, OVERSAMPLE=16, and the sample-index constants 7/8/9/15.
REQ-029 Tick generation SHALL be sub-module dbg_uart_tick_gen (counter, tick output, synchronous restart input).
REQ-030 Total RTL SHALL be 120-400 lines.

Verification (TICK_DIV=10, bit = 160 cycles)
REQ-031 Send 0xA5 with ready_i=1 -> data_o=0xA5, valid_o for 1 cycle, about 1532±20 cycles after the falling edge.
REQ-032 Drive rx low for 40 cycles, then high -> no valid_o, busy_o back to 0 within 80 cycles.
REQ-033 Send 0x3C with stop bit 0 -> frame_err_o one pulse, valid_o stays 0; a following 0x3C with a correct stop bit is received.
REQ-034 Send 0x11 then 0x22 with ready_i=0 -> data_o=0x11 held, overrun_o one pulse at the second stop; then ready_i=1 -> valid_o drops.
REQ-035 Back-to-back 0x00, 0xFF, ready_i=1 -> two valid beats with correct data, no errors.
REQ-036 Assert reset during data bit 4 -> all outputs 0; after release, 0x5A is received correctly.
